// File: rtl/fdiv_pkg.sv
// Shared definitions for the programmable clock divider: the controller state
// encoding and the smallest ratio that still yields a real clock.
package fdiv_pkg;

    // Controller states: OFF = idle with y low, RUN = dividing,
    // PEND = a new ratio is waiting for the next period boundary.
    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    // A ratio below 2 cannot produce both a high and a low phase.
    localparam int MIN_DIV = 2;

endpackage

// File: rtl/fdiv_core.sv
// Period counter and 50 % duty waveform generator. The controller decides when
// a period starts (restart) and whether the divider keeps running (en). The core
// reports the last cycle of each period (boundary) back to the controller.
module fdiv_core
    import fdiv_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic         restart,
    input  logic [W-1:0] active_div,
    output logic         boundary,
    output logic         tick,
    output logic         y
);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_inc;
    logic [W-1:0] half;
    logic         running;
    logic         p;
    logic         n;

    // The increment is only used off the boundary, where cnt < active_div-1,
    // so it stays within W bits even for the largest ratio.
    assign cnt_inc  = cnt + W'(1);
    assign half     = active_div >> 1;
    // active_div is never below MIN_DIV, so the subtraction cannot wrap.
    assign boundary = running && (cnt == active_div - W'(1));

    // Posedge phase: count through the period, p high for the first floor(D/2) cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            running <= 1'b0;
            cnt     <= '0;
            p       <= 1'b0;
            tick    <= 1'b0;
        end else if (!en) begin
            running <= 1'b0;
            cnt     <= '0;
            p       <= 1'b0;
            tick    <= 1'b0;
        end else if (restart) begin
            // floor(D/2) >= 1 for any legal ratio, so every period opens high.
            running <= 1'b1;
            cnt     <= '0;
            p       <= 1'b1;
            tick    <= 1'b1;
        end else begin
            cnt     <= cnt_inc;
            p       <= (cnt_inc < half);
            tick    <= 1'b0;
        end
    end

    // Negedge copy of p: stretches the high phase by half a cycle for odd ratios.
    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            n <= 1'b0;
        end else begin
            n <= p;
        end
    end

    // Ratio changes only land on a boundary, where p and n are both low, so the
    // odd/even select never switches while y is high.
    assign y = active_div[0] ? (p | n) : p;

endmodule

// File: rtl/fdiv_ctrl.sv
// Run-time programmable clock divider controller. Accepts new ratios over a
// valid/ready port and only applies them at a period boundary so y never glitches.
//
// Handshake: a ratio is transferred on every rising clk edge where cfg_valid
// and cfg_ready are both 1. cfg_ready does not depend on cfg_valid in the same
// cycle. An illegal ratio still completes the transfer and is then dropped,
// reported by cfg_err the following cycle.
module fdiv_ctrl
    import fdiv_pkg::*;
#(
    parameter int W           = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         run,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_div,
    output logic         cfg_ready,
    output logic         cfg_err,
    output logic         cfg_done,
    output logic [W-1:0] active_div,
    output logic         tick,
    output logic         y
);

    state_t       state;
    state_t       next_state;
    logic [W-1:0] pend_div;
    logic         boundary;
    logic         hs;
    logic         legal;
    logic         core_en;
    logic         core_restart;

    assign hs    = cfg_valid & cfg_ready;
    assign legal = (cfg_div >= W'(MIN_DIV));

    // Next-state decision, shared by the FSM register and the core controls.
    always_comb begin
        next_state = state;
        case (state)
            OFF: begin
                if (run) next_state = RUN;
            end
            RUN: begin
                // A fresh ratio wins over stopping: it is applied, then run is re-evaluated.
                if (hs && legal)          next_state = PEND;
                else if (boundary && !run) next_state = OFF;
            end
            PEND: begin
                if (boundary) next_state = run ? RUN : OFF;
            end
            default: next_state = OFF;
        endcase
    end

    // Leaving OFF always opens a new period; while running, a new one opens at each boundary.
    assign core_en      = (next_state != OFF);
    assign core_restart = (state == OFF) || boundary;

    // Controller FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= OFF;
            active_div <= W'(DEFAULT_DIV);
            pend_div   <= W'(DEFAULT_DIV);
            cfg_ready  <= 1'b1;
            cfg_err    <= 1'b0;
            cfg_done   <= 1'b0;
        end else begin
            state     <= next_state;
            cfg_ready <= (next_state != PEND);
            cfg_err   <= hs && !legal;
            cfg_done  <= 1'b0;
            if (state == OFF && hs && legal) begin
                // Nothing is running, so the ratio can take effect immediately.
                active_div <= cfg_div;
                cfg_done   <= 1'b1;
            end
            if (state == RUN && hs && legal) begin
                pend_div <= cfg_div;
            end
            if (state == PEND && boundary) begin
                active_div <= pend_div;
                cfg_done   <= 1'b1;
            end
        end
    end

    fdiv_core #(
        .W (W)
    ) u_core (
        .clk        (clk),
        .rstn       (rstn),
        .en         (core_en),
        .restart    (core_restart),
        .active_div (active_div),
        .boundary   (boundary),
        .tick       (tick),
        .y          (y)
    );

endmodule
